// File: rtl/adder_arbiter.sv
// Round-robin front end that shares one pipelined 32-bit adder between NREQ requesters.
// A tag pipeline matched to the adder latency routes each result back to its issuer.
module adder_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned ADD_LAT = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hold,

    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    input  logic [NREQ-1:0]      req_cin,

    output logic [31:0]          add_a,
    output logic [31:0]          add_b,
    output logic                 add_cin,
    input  logic [31:0]          add_sum,
    input  logic                 add_cout,

    output logic [NREQ-1:0]      rsp_valid,
    output logic [31:0]          rsp_sum,
    output logic                 rsp_cout,
    output logic                 busy,
    output logic [CNT_W-1:0]     ops_done
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             grant_found;
    logic [PTR_W-1:0] grant_idx;
    logic             accept;
    int               scan_idx;

    logic [31:0]      add_a_q, add_a_d;
    logic [31:0]      add_b_q, add_b_d;
    logic             add_cin_q, add_cin_d;

    logic [ADD_LAT:0] tag_vld_q, tag_vld_d;
    logic [PTR_W-1:0] tag_id_q [ADD_LAT+1];
    logic [PTR_W-1:0] tag_id_d [ADD_LAT+1];

    logic [CNT_W-1:0] ops_done_q, ops_done_d;

    // Scan ptr, ptr+1, ... modulo NREQ; the first valid requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        for (int k = 0; k < int'(NREQ); k++) begin
            scan_idx = (int'(ptr_q) + k) % int'(NREQ);
            if (!grant_found && req_valid[PTR_W'(scan_idx)]) begin
                grant_found = 1'b1;
                grant_idx   = PTR_W'(scan_idx);
            end
        end
    end

    assign accept = grant_found && !hold && !rst;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        add_a_d   = add_a_q;
        add_b_d   = add_b_q;
        add_cin_d = add_cin_q;
        if (accept) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                if (grant_idx == PTR_W'(i)) begin
                    add_a_d   = req_a[32*i +: 32];
                    add_b_d   = req_b[32*i +: 32];
                    add_cin_d = req_cin[i];
                end
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            if (grant_idx == PTR_W'(NREQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx + PTR_W'(1);
            end
        end
    end

    // Tags shift every edge without stalling, mirroring the adder's fixed latency.
    always_comb begin
        tag_vld_d    = '0;
        tag_vld_d[0] = accept;
        tag_id_d[0]  = grant_idx;
        for (int s = 1; s <= int'(ADD_LAT); s++) begin
            tag_vld_d[s] = tag_vld_q[s-1];
            tag_id_d[s]  = tag_id_q[s-1];
        end
    end

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            rsp_valid[i] = tag_vld_q[ADD_LAT] && (tag_id_q[ADD_LAT] == PTR_W'(i));
        end
    end

    always_comb begin
        ops_done_d = ops_done_q;
        if (|rsp_valid) begin
            ops_done_d = ops_done_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            add_a_q    <= '0;
            add_b_q    <= '0;
            add_cin_q  <= 1'b0;
            tag_vld_q  <= '0;
            ops_done_q <= '0;
            for (int s = 0; s <= int'(ADD_LAT); s++) begin
                tag_id_q[s] <= '0;
            end
        end else begin
            ptr_q      <= ptr_d;
            add_a_q    <= add_a_d;
            add_b_q    <= add_b_d;
            add_cin_q  <= add_cin_d;
            tag_vld_q  <= tag_vld_d;
            ops_done_q <= ops_done_d;
            for (int s = 0; s <= int'(ADD_LAT); s++) begin
                tag_id_q[s] <= tag_id_d[s];
            end
        end
    end

    assign add_a    = add_a_q;
    assign add_b    = add_b_q;
    assign add_cin  = add_cin_q;
    assign rsp_sum  = add_sum;
    assign rsp_cout = add_cout;
    assign busy     = |tag_vld_q;
    assign ops_done = ops_done_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter with a behavioural 2-stage adder attached.
module tb_adder_arbiter;

    logic         clk;
    logic         rst;
    logic         hold;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [3:0]   req_cin;
    logic [31:0]  add_a;
    logic [31:0]  add_b;
    logic         add_cin;
    logic [31:0]  add_sum;
    logic         add_cout;
    logic [3:0]   rsp_valid;
    logic [31:0]  rsp_sum;
    logic         rsp_cout;
    logic         busy;
    logic [15:0]  ops_done;

    int checks;
    int errors;

    adder_arbiter #(.NREQ(4), .ADD_LAT(2), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .hold      (hold),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .rsp_valid (rsp_valid),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .busy      (busy),
        .ops_done  (ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared adder: operand register then result register.
    logic [32:0] s1_q, s2_q;
    always @(posedge clk) begin
        s1_q <= {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};
        s2_q <= s1_q;
    end
    assign add_sum  = s2_q[31:0];
    assign add_cout = s2_q[32];

    // Fixed operands per requester; expected results computed by hand.
    //   r0: 5 + 7 + 1                   = 0x0000000D, cout 0
    //   r1: 0xFFFFFFFF + 1 + 0          = 0x00000000, cout 1
    //   r2: 0x80000000 + 0x80000000 + 0 = 0x00000000, cout 1
    //   r3: 0x12345678 + 0x11111111 + 1 = 0x2345678A, cout 0
    assign req_a   = {32'h1234_5678, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0005};
    assign req_b   = {32'h1111_1111, 32'h8000_0000, 32'h0000_0001, 32'h0000_0007};
    assign req_cin = 4'b1001;

    logic [31:0] exp_sum  [4];
    logic        exp_cout [4];
    initial begin
        exp_sum[0] = 32'h0000_000D; exp_cout[0] = 1'b0;
        exp_sum[1] = 32'h0000_0000; exp_cout[1] = 1'b1;
        exp_sum[2] = 32'h0000_0000; exp_cout[2] = 1'b1;
        exp_sum[3] = 32'h2345_678A; exp_cout[3] = 1'b0;
    end

    typedef struct {
        logic        hold;
        logic [3:0]  rv;
        logic [3:0]  ready;
        logic [3:0]  rsp;
        logic [31:0] sum;
        logic        cout;
        logic        busy;
        logic [15:0] done;
    } vec_t;

    vec_t tbl [27];

    function automatic vec_t mk(input logic h, input logic [3:0] rv, input logic [3:0] rdy,
                                input logic [3:0] rsp, input logic [31:0] sum, input logic co,
                                input logic bsy, input logic [15:0] done);
        vec_t v;
        v.hold = h; v.rv = rv; v.ready = rdy; v.rsp = rsp;
        v.sum = sum; v.cout = co; v.busy = bsy; v.done = done;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs, compare at the falling edge, then advance past the rising edge.
    task automatic cyc(input string nm, input logic h, input logic [3:0] rv,
                       input logic [3:0] e_rdy, input logic [3:0] e_rsp, input logic [31:0] e_sum,
                       input logic e_co, input logic e_busy, input logic [15:0] e_done);
        hold      = h;
        req_valid = rv;
        @(negedge clk);
        chk({nm, ".req_ready"}, {28'd0, req_ready}, {28'd0, e_rdy});
        chk({nm, ".rsp_valid"}, {28'd0, rsp_valid}, {28'd0, e_rsp});
        if (e_rsp != 4'd0) begin
            chk({nm, ".rsp_sum"}, rsp_sum, e_sum);
            chk({nm, ".rsp_cout"}, {31'd0, rsp_cout}, {31'd0, e_co});
        end
        chk({nm, ".busy"}, {31'd0, busy}, {31'd0, e_busy});
        chk({nm, ".ops_done"}, {16'd0, ops_done}, {16'd0, e_done});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string nm);
        rst       = 1'b1;
        hold      = 1'b0;
        req_valid = 4'b1111;
        @(negedge clk);
        chk({nm, ".ready_in_rst"}, {28'd0, req_ready}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = 4'b0000;
    endtask

    logic [3:0] one;

    initial begin
        checks = 0;
        errors = 0;
        one    = 4'b0001;
        rst    = 1'b1;
        hold   = 1'b0;
        req_valid = 4'b0000;
        @(posedge clk);
        do_reset("rst0");
        chk("rst0.add_a", add_a, 32'd0);
        chk("rst0.add_b", add_b, 32'd0);
        chk("rst0.add_cin", {31'd0, add_cin}, 32'd0);

        //          hold  rv       ready    rsp      sum            cout busy done
        tbl[0]  = mk(1'b0, 4'b0010, 4'b0010, 4'b0000, 32'h0,         1'b0, 1'b0, 16'd0);
        tbl[1]  = mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 32'h0,         1'b0, 1'b1, 16'd0);
        tbl[2]  = mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 32'h0,         1'b0, 1'b1, 16'd0);
        tbl[3]  = mk(1'b0, 4'b0000, 4'b0000, 4'b0010, 32'h0,         1'b1, 1'b1, 16'd0);
        tbl[4]  = mk(1'b0, 4'b1011, 4'b1000, 4'b0000, 32'h0,         1'b0, 1'b0, 16'd1);
        tbl[5]  = mk(1'b0, 4'b0011, 4'b0001, 4'b0000, 32'h0,         1'b0, 1'b1, 16'd1);
        tbl[6]  = mk(1'b0, 4'b0010, 4'b0010, 4'b0000, 32'h0,         1'b0, 1'b1, 16'd1);
        tbl[7]  = mk(1'b0, 4'b0000, 4'b0000, 4'b1000, 32'h2345_678A, 1'b0, 1'b1, 16'd1);
        tbl[8]  = mk(1'b0, 4'b0000, 4'b0000, 4'b0001, 32'h0000_000D, 1'b0, 1'b1, 16'd2);
        tbl[9]  = mk(1'b0, 4'b0000, 4'b0000, 4'b0010, 32'h0,         1'b1, 1'b1, 16'd3);
        tbl[10] = mk(1'b0, 4'b0101, 4'b0100, 4'b0000, 32'h0,         1'b0, 1'b0, 16'd4);
        tbl[11] = mk(1'b0, 4'b0001, 4'b0001, 4'b0000, 32'h0,         1'b0, 1'b1, 16'd4);
        tbl[12] = mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 32'h0,         1'b0, 1'b1, 16'd4);
        tbl[13] = mk(1'b0, 4'b0000, 4'b0000, 4'b0100, 32'h0,         1'b1, 1'b1, 16'd4);
        tbl[14] = mk(1'b0, 4'b0000, 4'b0000, 4'b0001, 32'h0000_000D, 1'b0, 1'b1, 16'd5);
        tbl[15] = mk(1'b0, 4'b1111, 4'b0010, 4'b0000, 32'h0,         1'b0, 1'b0, 16'd6);
        tbl[16] = mk(1'b0, 4'b1101, 4'b0100, 4'b0000, 32'h0,         1'b0, 1'b1, 16'd6);
        tbl[17] = mk(1'b0, 4'b1001, 4'b1000, 4'b0000, 32'h0,         1'b0, 1'b1, 16'd6);
        tbl[18] = mk(1'b1, 4'b0001, 4'b0000, 4'b0010, 32'h0,         1'b1, 1'b1, 16'd6);
        tbl[19] = mk(1'b1, 4'b0001, 4'b0000, 4'b0100, 32'h0,         1'b1, 1'b1, 16'd7);
        tbl[20] = mk(1'b1, 4'b0001, 4'b0000, 4'b1000, 32'h2345_678A, 1'b0, 1'b1, 16'd8);
        tbl[21] = mk(1'b1, 4'b0001, 4'b0000, 4'b0000, 32'h0,         1'b0, 1'b0, 16'd9);
        tbl[22] = mk(1'b0, 4'b0011, 4'b0001, 4'b0000, 32'h0,         1'b0, 1'b0, 16'd9);
        tbl[23] = mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 32'h0,         1'b0, 1'b1, 16'd9);
        tbl[24] = mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 32'h0,         1'b0, 1'b1, 16'd9);
        tbl[25] = mk(1'b0, 4'b0000, 4'b0000, 4'b0001, 32'h0000_000D, 1'b0, 1'b1, 16'd9);
        tbl[26] = mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 32'h0,         1'b0, 1'b0, 16'd10);

        for (int i = 0; i < 27; i++) begin
            cyc($sformatf("tbl%0d", i), tbl[i].hold, tbl[i].rv, tbl[i].ready, tbl[i].rsp,
                tbl[i].sum, tbl[i].cout, tbl[i].busy, tbl[i].done);
        end

        // All four requesters valid continuously from reset: grants 0,1,2,3,... one rsp per cycle.
        do_reset("rst1");
        for (int c = 0; c < 16; c++) begin
            cyc($sformatf("rr%0d", c), 1'b0,
                (c < 12) ? 4'b1111 : 4'b0000,
                (c < 12) ? (one << (c % 4)) : 4'b0000,
                (c >= 3 && c <= 14) ? (one << ((c + 1) % 4)) : 4'b0000,
                exp_sum[(c + 1) % 4], exp_cout[(c + 1) % 4],
                (c >= 1 && c <= 14) ? 1'b1 : 1'b0,
                (c >= 3) ? 16'(c - 3) : 16'd0);
        end

        // Two ops in flight, then reset: both must vanish and ptr must return to 0.
        do_reset("rst2");
        cyc("mf0", 1'b0, 4'b0001, 4'b0001, 4'b0000, 32'h0, 1'b0, 1'b0, 16'd0);
        cyc("mf1", 1'b0, 4'b0010, 4'b0010, 4'b0000, 32'h0, 1'b0, 1'b1, 16'd0);
        rst       = 1'b1;
        req_valid = 4'b1111;
        @(negedge clk);
        chk("mf_rst.req_ready", {28'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mf_rst.add_a", add_a, 32'd0);
        chk("mf_rst.busy", {31'd0, busy}, 32'd0);
        // Carry-in and ordering: r0 then r2 back-to-back.
        cyc("co0", 1'b0, 4'b0101, 4'b0001, 4'b0000, 32'h0, 1'b0, 1'b0, 16'd0);
        chk("co0.add_a", add_a, 32'd5);
        chk("co0.add_b", add_b, 32'd7);
        chk("co0.add_cin", {31'd0, add_cin}, 32'd1);
        cyc("co1", 1'b0, 4'b0100, 4'b0100, 4'b0000, 32'h0, 1'b0, 1'b1, 16'd0);
        cyc("co2", 1'b0, 4'b0000, 4'b0000, 4'b0000, 32'h0, 1'b0, 1'b1, 16'd0);
        cyc("co3", 1'b0, 4'b0000, 4'b0000, 4'b0001, 32'h0000_000D, 1'b0, 1'b1, 16'd0);
        cyc("co4", 1'b0, 4'b0000, 4'b0000, 4'b0100, 32'h0, 1'b1, 1'b1, 16'd1);
        cyc("co5", 1'b0, 4'b0000, 4'b0000, 4'b0000, 32'h0, 1'b0, 1'b0, 16'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
